sr_drive_encoder: RTL and testbench
===================================

Name: sr_drive_encoder

Overview:
- Command-side counterpart of the SR_FF block. Accepts a target state vector over a valid/ready handshake and generates S/R pulse pairs that drive WIDTH SR flip-flops to that state.
- Keeps an internal model of the flip-flop states. Only bits that must change get a pulse.
- Guarantees the forbidden S=R=1 condition never occurs on any bit.
- Sits between control logic and a bank of SR_FF instances.

Parameters:
WIDTH, 4, number of SR flip-flop channels driven
PULSE_CYC, 2, CLK cycles S/R held asserted per command (>=1)
GAP_CYC, 1, CLK cycles S=R=0 after pulse before completion (>=1)

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
TGT_VALID  input  1  target command valid
TGT_READY  output  1  encoder can accept a command
TGT  input  WIDTH  requested flip-flop states
FORCE_ALL  input  1  sampled with TGT; drive every bit regardless of model
S  output  WIDTH  set pulses to SR flip-flops
R  output  WIDTH  reset pulses to SR flip-flops
Q_MODEL  output  WIDTH  tracked flip-flop state
BUSY  output  1  command in progress
DONE  output  1  one-cycle completion strobe

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State=IDLE.
  - S=0, R=0, Q_MODEL=0, DONE=0, BUSY=0, counter=0.
  - TGT_READY=1.
- All of S, R, Q_MODEL, DONE and BUSY are registered. TGT_READY = (state==IDLE), decoded from state.
- Accept: a command is accepted on a rising edge where TGT_VALID=1 and TGT_READY=1 (edge E0).
- Masks computed at accept:
  - FORCE_ALL=0: set_mask = TGT & ~Q_MODEL; clr_mask = ~TGT & Q_MODEL.
  - FORCE_ALL=1: set_mask = TGT; clr_mask = ~TGT.
- No-change case (FORCE_ALL=0 and both masks 0):
  - State stays IDLE; DONE=1 for the cycle after E0.
  - S and R stay 0; BUSY stays 0.
- States:
  - IDLE --accept with nonzero masks--> PULSE. S=set_mask, R=clr_mask, BUSY=1 from E0 on.
  - PULSE holds S/R for exactly PULSE_CYC cycles, then --> GAP. On that edge: S=R=0, Q_MODEL=TGT (captured at E0).
  - GAP holds for GAP_CYC cycles with S=R=0, then --> IDLE. On that edge: DONE=1 for one cycle, BUSY=0.
- Latency: E0 to DONE high = 1+PULSE_CYC+GAP_CYC edges (4 with defaults). No-change latency is 1.
- Invariant: (S & R)==0 on every cycle, every bit. set_mask and clr_mask are disjoint by construction.
- TGT and FORCE_ALL are captured at E0. Input changes during PULSE/GAP are ignored.
- TGT_VALID while busy: the command is held off (TGT_READY=0). No command is dropped and none is queued internally.
- Back-to-back: TGT_READY=1 in the DONE cycle, so a new command may be accepted on the same edge DONE falls.
- Counter: width $clog2(max(PULSE_CYC,GAP_CYC))+1. Reloaded on each state entry, no wrap.
- Reset mid-operation: S and R drop to 0 asynchronously and Q_MODEL=0. The physical flip-flops may then disagree with the model, so the host must issue a FORCE_ALL=1 command to resynchronise.

Test Plan:
1. Assert RST_N=0 at any time -> S=0000, R=0000, Q_MODEL=0000, DONE=0, BUSY=0, TGT_READY=1, all asynchronously.
2. Model 0000, accept TGT=1010 -> S=1010, R=0000 for 2 cycles, then 1 gap cycle with S=R=0, DONE at edge 4, Q_MODEL=1010. SR_FF on bit 1 shows Q=1, Q_BAR=0.
3. Model 1010, accept TGT=0110 -> S=0100 and R=1000 for 2 cycles. Assertion (S&R)==0 holds every cycle. Q_MODEL=0110 afterwards.
4. Model 0110, accept TGT=0110, FORCE_ALL=0 -> no S/R activity, DONE high the next cycle, BUSY never 1.
5. FORCE_ALL=1, TGT=0011 with model 0011 -> S=0011, R=1100 for 2 cycles, DONE at edge 4.
6. Hold TGT_VALID=1 continuously with TGT 1111 then 0000 -> second command accepted on the DONE edge of the first. Pull RST_N low during the second PULSE -> S=R=0 immediately, Q_MODEL=0000, TGT_READY=1.

Source files
------------

// File: rtl/sr_drive_encoder.sv
// -----------------------------------------------------------------------------
// sr_drive_encoder
//
// Accepts a target state vector and turns it into S/R pulse pairs for a bank of
// WIDTH SR flip-flops. An internal model of the flip-flop states is kept, so
// only bits that must change get a pulse. FORCE_ALL drives every bit instead,
// which resynchronises the physical flip-flops with the model. S and R are
// never both high on the same bit.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   TGT_VALID  in   target command valid
//   TGT_READY  out  encoder can accept a command (high while IDLE)
//   TGT        in   requested flip-flop states [WIDTH]
//   FORCE_ALL  in   sampled with TGT; pulse every bit regardless of the model
//   S          out  set pulses [WIDTH]
//   R          out  reset pulses [WIDTH]
//   Q_MODEL    out  tracked flip-flop state [WIDTH]
//   BUSY       out  command in progress
//   DONE       out  one-cycle completion strobe
// -----------------------------------------------------------------------------
module sr_drive_encoder #(
    parameter int WIDTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TGT_VALID,
    output logic             TGT_READY,
    input  logic [WIDTH-1:0] TGT,
    input  logic             FORCE_ALL,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q_MODEL,
    output logic             BUSY,
    output logic             DONE
);

    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // The counter is loaded with (cycles - 1) on state entry and the state is
    // left when it reads zero, so a state lasts exactly the requested cycles.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   tgt_q, tgt_nxt;
    logic [WIDTH-1:0]   s_nxt, r_nxt, q_nxt;
    logic               busy_nxt, done_nxt;
    logic [WIDTH-1:0]   set_mask, clr_mask;

    assign TGT_READY = (state == ST_IDLE);

    // set_mask and clr_mask are disjoint by construction in both modes, which
    // is what keeps S & R == 0 on every bit.
    always_comb begin
        if (FORCE_ALL) begin
            set_mask = TGT;
            clr_mask = ~TGT;
        end else begin
            set_mask = TGT & ~Q_MODEL;
            clr_mask = ~TGT & Q_MODEL;
        end
    end

    // NOTE: every signal gets a default before the case statement so no path
    // leaves one unassigned; combinational logic uses blocking assignments.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt_q;
        s_nxt     = S;
        r_nxt     = R;
        q_nxt     = Q_MODEL;
        busy_nxt  = BUSY;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (TGT_VALID) begin
                    tgt_nxt = TGT;
                    if ((set_mask | clr_mask) != '0) begin
                        state_nxt = ST_PULSE;
                        s_nxt     = set_mask;
                        r_nxt     = clr_mask;
                        busy_nxt  = 1'b1;
                        cnt_nxt   = PULSE_LOAD;
                    end else begin
                        // Model already matches: complete without pulsing.
                        done_nxt = 1'b1;
                    end
                end
            end

            ST_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    s_nxt     = '0;
                    r_nxt     = '0;
                    q_nxt     = tgt_q;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                s_nxt     = '0;
                r_nxt     = '0;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the async reset drops S/R immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tgt_q   <= '0;
            S       <= '0;
            R       <= '0;
            Q_MODEL <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tgt_q   <= tgt_nxt;
            S       <= s_nxt;
            R       <= r_nxt;
            Q_MODEL <= q_nxt;
            BUSY    <= busy_nxt;
            DONE    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sr_drive_encoder.sv
// -----------------------------------------------------------------------------
// tb_sr_drive_encoder
//
// Directed bench for sr_drive_encoder with default parameters (WIDTH=4,
// PULSE_CYC=2, GAP_CYC=1). Inputs change just after the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
// A small behavioural SR flip-flop bank stands in for the downstream SR_FFs.
// -----------------------------------------------------------------------------
module tb_sr_drive_encoder;

    logic       CLK;
    logic       RST_N;
    logic       TGT_VALID;
    logic       TGT_READY;
    logic [3:0] TGT;
    logic       FORCE_ALL;
    logic [3:0] S;
    logic [3:0] R;
    logic [3:0] Q_MODEL;
    logic       BUSY;
    logic       DONE;

    int vectors     = 0;
    int miscompares = 0;

    sr_drive_encoder #(
        .WIDTH     (4),
        .PULSE_CYC (2),
        .GAP_CYC   (1)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .TGT_VALID (TGT_VALID),
        .TGT_READY (TGT_READY),
        .TGT       (TGT),
        .FORCE_ALL (FORCE_ALL),
        .S         (S),
        .R         (R),
        .Q_MODEL   (Q_MODEL),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Downstream SR flip-flop bank; deliberately not tied to RST_N.
    logic [3:0] ff_q = 4'b0000;
    always @(posedge CLK) ff_q <= (ff_q & ~R) | S;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic [3:0] s_e, input logic [3:0] r_e,
                              input logic [3:0] q_e, input logic busy_e,
                              input logic done_e, input logic ready_e);
        check({tag, "_s"},       32'(S),         32'(s_e));
        check({tag, "_r"},       32'(R),         32'(r_e));
        check({tag, "_qmodel"},  32'(Q_MODEL),   32'(q_e));
        check({tag, "_busy"},    32'(BUSY),      32'(busy_e));
        check({tag, "_done"},    32'(DONE),      32'(done_e));
        check({tag, "_ready"},   32'(TGT_READY), 32'(ready_e));
        check({tag, "_overlap"}, 32'(S & R),     32'(0));
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        RST_N     = 1'b0;
        TGT_VALID = 1'b0;
        TGT       = 4'b0000;
        FORCE_ALL = 1'b0;

        // 1: reset state, before any clock edge
        #1;
        expect_out("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // 2: model 0000 -> 1010
        TGT = 4'b1010; TGT_VALID = 1'b1;
        tick();
        TGT_VALID = 1'b0; TGT = 4'b0000;
        expect_out("t2_e0", 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t2_e1", 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t2_gap", 4'b0000, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t2_done", 4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b1);
        check("t2_ff_bit1", 32'(ff_q[1]), 32'(1));
        tick();
        expect_out("t2_idle", 4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b1);

        // 3: model 1010 -> 0110
        TGT = 4'b0110; TGT_VALID = 1'b1;
        tick();
        TGT_VALID = 1'b0;
        expect_out("t3_e0", 4'b0100, 4'b1000, 4'b1010, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t3_e1", 4'b0100, 4'b1000, 4'b1010, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t3_gap", 4'b0000, 4'b0000, 4'b0110, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t3_done", 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b1, 1'b1);
        tick();

        // 4: no-change command
        TGT = 4'b0110; FORCE_ALL = 1'b0; TGT_VALID = 1'b1;
        tick();
        TGT_VALID = 1'b0;
        expect_out("t4_done", 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("t4_idle", 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b0, 1'b1);

        // bring model to 0011
        TGT = 4'b0011; TGT_VALID = 1'b1;
        tick();
        TGT_VALID = 1'b0;
        expect_out("prep_e0", 4'b0001, 4'b0100, 4'b0110, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        expect_out("prep_done", 4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b1);
        tick();

        // 5: FORCE_ALL with model already matching
        TGT = 4'b0011; FORCE_ALL = 1'b1; TGT_VALID = 1'b1;
        tick();
        TGT_VALID = 1'b0; FORCE_ALL = 1'b0;
        expect_out("t5_e0", 4'b0011, 4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t5_e1", 4'b0011, 4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t5_gap", 4'b0000, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t5_done", 4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b1);
        check("t5_ff_bank", 32'(ff_q), 32'(4'b0011));
        tick();

        // 6: TGT_VALID held, back-to-back, then reset mid-pulse
        TGT = 4'b1111; TGT_VALID = 1'b1;
        tick();
        TGT = 4'b0000;
        expect_out("t6_a_e0", 4'b1100, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t6_a_e1", 4'b1100, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t6_a_gap", 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("t6_a_done", 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1);
        tick();
        TGT_VALID = 1'b0;
        expect_out("t6_b_e0", 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        expect_out("t6_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        RST_N = 1'b1;
        tick();
        expect_out("t6_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
